power_seq: RTL and testbench

POWER_SEQ -- requirements
Module: power_seq

---
 rtl/power_seq.sv | 175 +++++++++++++++++
 tb/tb_power_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_seq.sv
// Four-rail power sequencer: ordered ramp-up with power-good checks,
// reverse-order ramp-down, fault latch. Delays come from an external ms timer.
module power_seq #(
    parameter int NUM_RAILS = 4,
    parameter int DLY_ON    = 10,
    parameter int DLY_OFF   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  pg,
    output logic [3:0]  rail_en,
    output logic        delay_en,
    output logic [31:0] delay_ms,
    input  logic        delay_done,
    output logic        ready,
    output logic        fault,
    output logic [1:0]  fault_rail
);

    typedef enum logic [2:0] {
        IDLE,
        RAIL_ON,
        WAIT_ON,
        CHECK_PG,
        READY,
        RAIL_OFF,
        WAIT_OFF,
        FAULT
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_RAILS - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] rail_en_q, rail_en_d;
    logic [1:0] fault_rail_q, fault_rail_d;

    logic       abort;
    logic       go_fault;
    logic       any_on;
    logic [1:0] top_idx;
    logic [1:0] low_fail;

    function automatic logic [3:0] bit_of(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            rail_en_q    <= 4'd0;
            fault_rail_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rail_en_q    <= rail_en_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    always_comb begin
        any_on   = |rail_en_q;
        top_idx  = 2'd0;
        low_fail = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rail_en_q[i]) top_idx = 2'(i);
        end
        for (int i = 3; i >= 0; i--) begin
            if (!pg[i]) low_fail = 2'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rail_en_d    = rail_en_q;
        fault_rail_d = fault_rail_q;
        abort        = 1'b0;
        go_fault     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RAIL_ON;
                    idx_d     = 2'd0;
                    rail_en_d = rail_en_q | bit_of(2'd0);
                end
            end
            RAIL_ON: begin
                if (!start) abort = 1'b1;
                else        state_d = WAIT_ON;
            end
            WAIT_ON: begin
                if (!start)          abort = 1'b1;
                else if (delay_done) state_d = CHECK_PG;
            end
            CHECK_PG: begin
                // A bad rail outranks a simultaneous power-down request.
                if (!pg[idx_q]) begin
                    go_fault     = 1'b1;
                    fault_rail_d = idx_q;
                end else if (!start) begin
                    abort = 1'b1;
                end else if (idx_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    state_d   = RAIL_ON;
                    idx_d     = idx_q + 2'd1;
                    rail_en_d = rail_en_q | bit_of(idx_q + 2'd1);
                end
            end
            READY: begin
                if (!(&pg)) begin
                    go_fault     = 1'b1;
                    fault_rail_d = low_fail;
                end else if (!start) begin
                    state_d   = RAIL_OFF;
                    idx_d     = LAST_IDX;
                    rail_en_d = rail_en_q & ~bit_of(LAST_IDX);
                end
            end
            RAIL_OFF: begin
                state_d = WAIT_OFF;
            end
            WAIT_OFF: begin
                if (delay_done) begin
                    if (idx_q != 2'd0) begin
                        state_d   = RAIL_OFF;
                        idx_d     = idx_q - 2'd1;
                        rail_en_d = rail_en_q & ~bit_of(idx_q - 2'd1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                if (!start) begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Unwind from the highest rail that actually got enabled.
        if (abort) begin
            if (any_on) begin
                state_d   = RAIL_OFF;
                idx_d     = top_idx;
                rail_en_d = rail_en_q & ~bit_of(top_idx);
            end else begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        end

        if (go_fault) begin
            state_d   = FAULT;
            rail_en_d = 4'd0;
        end
    end

    assign rail_en    = rail_en_q;
    assign delay_en   = (state_q == WAIT_ON) || (state_q == WAIT_OFF);
    assign delay_ms   = (state_q == WAIT_ON)  ? 32'(DLY_ON)  :
                        (state_q == WAIT_OFF) ? 32'(DLY_OFF) : 32'd0;
    assign ready      = (state_q == READY);
    assign fault      = (state_q == FAULT);
    assign fault_rail = fault_rail_q;

endmodule

// File: tb/tb_power_seq.sv
// Bench for power_seq: 1 ms == 1 clk timer, count-of-rails reference model,
// vector table, hand corner sequences and a randomized run.
module tb_power_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  pg;
    logic [3:0]  rail_en;
    logic        delay_en;
    logic [31:0] delay_ms;
    logic        delay_done;
    logic        ready;
    logic        fault;
    logic [1:0]  fault_rail;

    logic        glitch;
    logic [31:0] tcnt;
    bit          chk_en;
    int          n_tests;
    int          n_fail;

    power_seq #(.NUM_RAILS(4), .DLY_ON(10), .DLY_OFF(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pg         (pg),
        .rail_en    (rail_en),
        .delay_en   (delay_en),
        .delay_ms   (delay_ms),
        .delay_done (delay_done),
        .ready      (ready),
        .fault      (fault),
        .fault_rail (fault_rail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer: counts while enabled, expires after delay_ms cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst)          tcnt <= 32'd0;
        else if (!delay_en) tcnt <= 32'd0;
        else               tcnt <= tcnt + 32'd1;
    end
    assign delay_done = glitch || (delay_en && (tcnt == delay_ms - 32'd1));

    // Reference model: mode, phase within a rail step, number of rails on.
    typedef enum int { M_OFF, M_UP, M_RDY, M_DN, M_FLT } mode_t;
    mode_t m_mode;
    int    m_ph;
    int    m_n;
    int    m_fr;

    task automatic model_step(input logic st, input logic [3:0] p,
                              input logic dn);
        case (m_mode)
            M_OFF: if (st) begin m_mode = M_UP; m_ph = 0; m_n = 1; end
            M_UP: begin
                if (m_ph == 2 && !p[m_n-1]) begin
                    m_mode = M_FLT; m_fr = m_n - 1; m_n = 0;
                end else if (!st) begin
                    m_mode = M_DN; m_ph = 0; m_n = m_n - 1;
                end else if (m_ph == 0) begin
                    m_ph = 1;
                end else if (m_ph == 1) begin
                    if (dn) m_ph = 2;
                end else if (m_n == 4) begin
                    m_mode = M_RDY;
                end else begin
                    m_n = m_n + 1; m_ph = 0;
                end
            end
            M_RDY: begin
                if (p != 4'hF) begin
                    m_fr = 0;
                    for (int i = 3; i >= 0; i--) if (!p[i]) m_fr = i;
                    m_mode = M_FLT; m_n = 0;
                end else if (!st) begin
                    m_mode = M_DN; m_ph = 0; m_n = 3;
                end
            end
            M_DN: begin
                if (m_ph == 0) m_ph = 1;
                else if (dn) begin
                    if (m_n == 0) m_mode = M_OFF;
                    else begin m_n = m_n - 1; m_ph = 0; end
                end
            end
            M_FLT: if (!st) m_mode = M_OFF;
            default: m_mode = M_OFF;
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_OFF; m_ph = 0; m_n = 0; m_fr = 0;
        end else begin
            model_step(start, pg, delay_done);
        end
    end

    function automatic logic [3:0] model_rails();
        return 4'((1 << m_n) - 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            logic        e_den;
            logic        e_flt;
            logic [31:0] e_ms;
            logic [40:0] a;
            logic [40:0] e;
            e_den = ((m_mode == M_UP) || (m_mode == M_DN)) && (m_ph == 1);
            e_flt = (m_mode == M_FLT);
            e_ms  = !e_den ? 32'd0 : (m_mode == M_UP) ? 32'd10 : 32'd5;
            a = {rail_en, delay_en, ready, fault,
                 e_flt ? fault_rail : 2'd0, e_den ? delay_ms : 32'd0};
            e = {model_rails(), e_den, 1'(m_mode == M_RDY), e_flt,
                 e_flt ? 2'(m_fr) : 2'd0, e_ms};
            check("model", 64'(a), 64'(e));
        end
    end

    task automatic drive(input int cycles, input logic st,
                         input logic [3:0] pg_and);
        for (int c = 0; c < cycles; c++) begin
            start = st;
            pg    = model_rails() & pg_and;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic       st;
        logic [3:0] pg_and;
        int         cycles;
        logic [3:0] e_rail;
        logic       e_ready;
        logic       e_fault;
        logic [1:0] e_fr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 4'b1111, 60, 4'b1111, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 30, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'b1011, 40, 4'b0000, 1'b0, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 4'b1111,  3, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 4'b1111, 60, 4'b1111, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 4'b1110,  2, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[6]  = '{1'b1, 4'b1111,  5, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b1111,  2, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{1'b1, 4'b1111, 20, 4'b0011, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 4'b1111,  1, 4'b0001, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 4'b1111, 15, 4'b0000, 1'b0, 1'b0, 2'd0};

        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst     = 1'b0;
        start   = 1'b0;
        pg      = 4'd0;
        glitch  = 1'b0;

        #12;
        check("reset_outs", 64'({rail_en, delay_en, delay_ms, ready, fault,
                                 fault_rail}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        for (int k = 0; k < 11; k++) begin
            drive(tbl[k].cycles, tbl[k].st, tbl[k].pg_and);
            check($sformatf("vec%0d", k),
                  64'({rail_en, ready, fault,
                       tbl[k].e_fault ? fault_rail : 2'd0}),
                  64'({tbl[k].e_rail, tbl[k].e_ready, tbl[k].e_fault,
                       tbl[k].e_fr}));
        end

        // Rail 2 drops while READY: fault next cycle, all rails off.
        drive(60, 1'b1, 4'b1111);
        check("rdy_before", 64'({ready, rail_en}), 64'({1'b1, 4'b1111}));
        drive(1, 1'b1, 4'b1011);
        check("rdy_pgdrop", 64'({rail_en, ready, fault, fault_rail}),
              64'({4'b0000, 1'b0, 1'b1, 2'd2}));
        drive(3, 1'b0, 4'b1111);
        check("flt_clear", 64'({fault, rail_en}), 64'd0);

        // Abort during WAIT_ON of rail 1: delay_en must drop between requests.
        drive(15, 1'b1, 4'b1111);
        check("abort_pre", 64'({rail_en, delay_en}), 64'({4'b0011, 1'b1}));
        drive(1, 1'b0, 4'b1111);
        check("abort_gap", 64'({rail_en, delay_en}), 64'({4'b0001, 1'b0}));
        drive(1, 1'b0, 4'b1111);
        check("abort_off", 64'({delay_en, delay_ms}), 64'({1'b1, 32'd5}));
        drive(12, 1'b0, 4'b1111);
        check("abort_idle", 64'({rail_en, delay_en, ready}), 64'd0);

        // Asynchronous reset during WAIT_ON of rail 2.
        drive(28, 1'b1, 4'b1111);
        check("wait2_pre", 64'({rail_en, delay_en}), 64'({4'b0111, 1'b1}));
        #2 rst = 1'b0;
        #1;
        check("async_rst", 64'({rail_en, delay_en, ready, fault}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(2, 1'b1, 4'b1111);
        check("post_rst", 64'({rail_en, delay_en}), 64'({4'b0001, 1'b1}));
        drive(30, 1'b0, 4'b1111);

        // Randomized run with stray timer pulses and pg dropouts.
        begin
            logic       st;
            logic [3:0] p;
            st = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 99) == 0) st = ~st;
                p = model_rails();
                if ($urandom_range(0, 199) == 0) p[$urandom_range(0, 3)] = 1'b0;
                glitch = ($urandom_range(0, 19) == 0);
                start  = st;
                pg     = p;
                @(negedge clk);
            end
            glitch = 1'b0;
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
